xbox_xlr_matmul: RTL and testbench
==================================

XBOX_XLR_MATMUL -- requirements
Module: xbox_xlr_matmul

Interface
REQ-001 Parameter NUM_MEMS, 2: memory instances; SHALL be at least 2. Mem 0 holds A and C; mem 1 holds B.
REQ-002 Parameter LOG2_LINES_PER_MEM, 4: address width per memory.
REQ-003 Parameter DIM, 4: square matrix dimension; legal range 2..8; each matrix row occupies one memory line, words [DIM-1:0].
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 xlr_mem_addr  output  [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  line address per memory.
REQ-007 xlr_mem_wdata  output  [NUM_MEMS-1:0][7:0][31:0]  write data per memory.
REQ-008 xlr_mem_be  output  [NUM_MEMS-1:0][31:0]  byte enables, one bit per byte.
REQ-009 xlr_mem_rd / xlr_mem_wr  output  [NUM_MEMS-1:0]  read and write strobes.
REQ-010 xlr_mem_rdata  input  [NUM_MEMS-1:0][7:0][31:0]  read data, valid the cycle after rd.
REQ-011 host_regs  input  [31:0][31:0]  register contents as written by the host.
REQ-012 host_regs_valid_pulse  input  [31:0]  one-cycle write strobe per register.
REQ-013 host_regs_data_out / host_regs_valid_out  output  [31:0][31:0] / [31:0]  status readback.

Function
REQ-014 Start SHALL be accepted only in IDLE, and only when host_regs_valid_pulse[0]=1 and host_regs[0][0]=1; a start in any other state SHALL be ignored.
REQ-015 On start, the block SHALL latch the base addresses from host_regs[1]: a_base=[LOG2-1:0], b_base=[8+LOG2-1:8], c_base=[16+LOG2-1:16].
REQ-016 States SHALL be IDLE, LOAD, COMPUTE, WRITE, DONE; DONE SHALL always return to IDLE after 1 cycle.
REQ-017 LOAD, DIM+1 cycles: in cycle k<DIM, rd[0]=rd[1]=1 and addr[0]=a_base+k, addr[1]=b_base+k; in cycle k>=1, capture row k-1 of both matrices from rdata.
REQ-018 COMPUTE, DIM*DIM cycles: produce one element C[i][j]=sum_k A[i][k]*B[k][j] per cycle, row-major; operands are unsigned 32-bit.
REQ-019 WRITE, DIM cycles: in cycle i, wr[0]=1, addr[0]=c_base+i, wdata[0] words[DIM-1:0]=C row i, unused words 0, be[0]=low 4*DIM bits set.
REQ-020 Base+offset address arithmetic SHALL wrap modulo 2^LOG2_LINES_PER_MEM.
REQ-021 Start pulse at cycle 0 SHALL give busy=1 from cycle 1 and DONE in cycle 2*DIM+DIM*DIM+2.
REQ-022 rd, wr and be SHALL be 0 outside LOAD and WRITE; mem 1 SHALL never be written; addr SHALL be 0 when idle.
REQ-023 host_regs_data_out[0]={31'b0,busy}, with busy=1 in LOAD/COMPUTE/WRITE; valid_out[0] SHALL be constantly 1.
REQ-024 host_regs_data_out[1][0]=done is sticky: set on entering DONE, cleared by the next accepted start; valid_out[1]=done.
REQ-025 All other host_regs_data_out words SHALL be 0 and their valid_out bits 0, except as given in REQ-031.

Reset
REQ-026 While rst_n=0: state=IDLE; busy, done, sat, all operand and result storage, and all memory outputs SHALL be 0.
REQ-027 Reset mid-operation SHALL abort immediately; no further memory write SHALL occur, and the partial C in memory is undefined.

Configuration
REQ-028 Macro XLR_MATMUL_SAT_EN selects the accumulation mode.
REQ-029 Without XLR_MATMUL_SAT_EN: products and sums SHALL be truncated modulo 2^32.
REQ-030 With XLR_MATMUL_SAT_EN: accumulation SHALL be in at least 2*32+log2(DIM) bits, and any element exceeding 32'hFFFFFFFF SHALL be clamped to 32'hFFFFFFFF.
REQ-031 With XLR_MATMUL_SAT_EN: sticky bit host_regs_data_out[1][1] SHALL be set on any clamp and cleared on start. Without the macro, this bit SHALL be 0.

Verification
REQ-032 DIM=2; A=[1 2;3 4] at line 0 of mem 0, B=[5 6;7 8] at line 0 of mem 1, c_base=2 -> mem 0 line 2={19,22}, line 3={43,50}, be=32'h000000FF; done at cycle 10.
REQ-033 DIM=4; A=identity, B=1..16 row-major -> C=B; 4 writes with be=32'h0000FFFF; done at cycle 26.
REQ-034 DIM=4; a_base=14 -> A rows read from lines 14, 15, 0, 1 (wrap).
REQ-035 Second start pulse during COMPUTE -> ignored; exactly one DONE and DIM writes occur.
REQ-036 All elements 32'hFFFFFFFF, DIM=2 -> with SAT_EN: C=32'hFFFFFFFF and sat=1; without it: C=32'h00000002 and sat=0.
REQ-037 rst_n low during WRITE after 1 row -> outputs 0 at once, no further wr; a new start completes a correct run.

Source files
------------

// File: rtl/xbox_xlr_matmul.sv
// xbox_xlr_matmul: DIMxDIM unsigned 32-bit matrix multiply, C = A*B, over memory ports.
// Optional macro XLR_MATMUL_SAT_EN: wide accumulation with clamp-to-max and a sticky sat flag.
module xbox_xlr_matmul #(
    parameter int NUM_MEMS = 2,
    parameter int LOG2_LINES_PER_MEM = 4,
    parameter int DIM = 4
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]    xlr_mem_addr,
    output logic [NUM_MEMS-1:0][7:0][31:0]                 xlr_mem_wdata,
    output logic [NUM_MEMS-1:0][31:0]                      xlr_mem_be,
    output logic [NUM_MEMS-1:0]                            xlr_mem_rd,
    output logic [NUM_MEMS-1:0]                            xlr_mem_wr,
    input  logic [NUM_MEMS-1:0][7:0][31:0]                 xlr_mem_rdata,
    input  logic [31:0][31:0]                              host_regs,
    input  logic [31:0]                                    host_regs_valid_pulse,
    output logic [31:0][31:0]                              host_regs_data_out,
    output logic [31:0]                                    host_regs_valid_out
);
    localparam int L = LOG2_LINES_PER_MEM;
    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [6:0] DIM7 = 7'(DIM);
    localparam logic [6:0] COMP_LAST = 7'(DIM * DIM - 1);
    localparam logic [6:0] WRITE_LAST = 7'(DIM - 1);
    localparam logic [31:0] BE_MASK = 32'hFFFFFFFF >> (32 - 4 * DIM);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;

    state_t state, state_nxt;
    logic [6:0] cnt;
    logic [L-1:0] a_base, b_base, c_base;
    logic [DIM-1:0][DIM-1:0][31:0] a_m, b_m, c_m;
    logic done, sat, busy, start, clamp;
    logic [31:0] elem;
    logic [IW-1:0] ci, cj, ri, rl;
    logic unused_ok;

    assign start = state == IDLE && host_regs_valid_pulse[0] && host_regs[0][0];
    assign busy = state inside {LOAD, COMPUTE, WRITE};
    assign ci = IW'(cnt / DIM7);
    assign cj = IW'(cnt % DIM7);
    assign ri = IW'(cnt);
    assign rl = IW'(cnt - 7'd1);
    assign unused_ok = ^{host_regs, host_regs_valid_pulse, xlr_mem_rdata};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // Next state and memory port drive; ports idle at zero outside LOAD/WRITE
    always_comb begin
        state_nxt = state;
        xlr_mem_addr = '0;
        xlr_mem_wdata = '0;
        xlr_mem_be = '0;
        xlr_mem_rd = '0;
        xlr_mem_wr = '0;
        case (state)
            IDLE: state_nxt = start ? LOAD : IDLE;
            LOAD: begin
                if (cnt != DIM7) begin
                    xlr_mem_rd[1:0] = 2'b11;
                    xlr_mem_addr[0] = a_base + L'(cnt);
                    xlr_mem_addr[1] = b_base + L'(cnt);
                end else begin
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: state_nxt = cnt == COMP_LAST ? WRITE : COMPUTE;
            WRITE: begin
                xlr_mem_wr[0] = 1'b1;
                xlr_mem_addr[0] = c_base + L'(cnt);
                xlr_mem_wdata[0][DIM-1:0] = c_m[ri];
                xlr_mem_be[0] = BE_MASK;
                state_nxt = cnt == WRITE_LAST ? DONE : WRITE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef XLR_MATMUL_SAT_EN
    logic [71:0] acc;

    // Dot product of row ci and column cj in wide precision, clamped to 32 bits
    always_comb begin
        acc = '0;
        for (int k = 0; k < DIM; k++) acc = acc + 72'(a_m[ci][k]) * 72'(b_m[k][cj]);
        clamp = |acc[71:32];
        elem = clamp ? 32'hFFFFFFFF : acc[31:0];
    end
`else
    logic [31:0] acc;

    // Dot product of row ci and column cj, wrapping modulo 2^32
    always_comb begin
        acc = '0;
        for (int k = 0; k < DIM; k++) acc = acc + a_m[ci][k] * b_m[k][cj];
        clamp = 1'b0;
        elem = acc;
    end
`endif

    // Phase counter, base latches, operand capture, result storage and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            a_base <= '0;
            b_base <= '0;
            c_base <= '0;
            a_m <= '0;
            b_m <= '0;
            c_m <= '0;
            done <= 1'b0;
            sat <= 1'b0;
        end else begin
            cnt <= state_nxt != state ? '0 : cnt + 7'd1;
            if (start) begin
                a_base <= host_regs[1][L-1:0];
                b_base <= host_regs[1][8+:L];
                c_base <= host_regs[1][16+:L];
                done <= 1'b0;
                sat <= 1'b0;
            end
            if (state == LOAD && cnt != '0) begin
                a_m[rl] <= xlr_mem_rdata[0][DIM-1:0];
                b_m[rl] <= xlr_mem_rdata[1][DIM-1:0];
            end
            if (state == COMPUTE) begin
                c_m[ci][cj] <= elem;
                sat <= sat | clamp;
            end
            if (state == WRITE && state_nxt == DONE) done <= 1'b1;
        end
    end

    // Status readback
    always_comb begin
        host_regs_data_out = '0;
        host_regs_data_out[0][0] = busy;
        host_regs_data_out[1][0] = done;
        host_regs_data_out[1][1] = sat;
    end

    assign host_regs_valid_out = {30'b0, done, 1'b1};
endmodule

// File: tb/tb_xbox_xlr_matmul.sv
// tb_xbox_xlr_matmul: directed checks of the DIM=4 matrix multiplier against a two-memory model.
module tb_xbox_xlr_matmul;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0][3:0] addr;
    logic [1:0][7:0][31:0] wdata;
    logic [1:0][31:0] be;
    logic [1:0] rd, wr;
    logic [1:0][7:0][31:0] rdata;
    logic [31:0][31:0] host_regs = '0;
    logic [31:0] pulse = '0;
    logic [31:0][31:0] data_out;
    logic [31:0] valid_out;
    logic busy, done, sat;
    int checks = 0, errors = 0;
    int wcount = 0, w1count = 0;
    logic [255:0] mem0 [16];
    logic [255:0] mem1 [16];
    logic [255:0] mrg, wflat;
    logic pl_en = 1'b0, pl_m = 1'b0;
    logic [3:0] pl_l = '0;
    logic [255:0] pl_d = '0;
    logic [31:0] last_be = '0, last_w4 = '0;
    int p [4] = '{1, 0, 3, 2};
    int cyc, w0, n;

`ifdef XLR_MATMUL_SAT_EN
    localparam logic [31:0] FF_C = 32'hFFFFFFFF;
    localparam logic FF_SAT = 1'b1;
`else
    localparam logic [31:0] FF_C = 32'h00000004;
    localparam logic FF_SAT = 1'b0;
`endif

    xbox_xlr_matmul #(.NUM_MEMS(2), .LOG2_LINES_PER_MEM(4), .DIM(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .xlr_mem_addr(addr),
        .xlr_mem_wdata(wdata),
        .xlr_mem_be(be),
        .xlr_mem_rd(rd),
        .xlr_mem_wr(wr),
        .xlr_mem_rdata(rdata),
        .host_regs(host_regs),
        .host_regs_valid_pulse(pulse),
        .host_regs_data_out(data_out),
        .host_regs_valid_out(valid_out)
    );

    always #5 clk = ~clk;

    assign busy = data_out[0][0];
    assign done = data_out[1][0];
    assign sat = data_out[1][1];
    assign wflat = wdata[0];

    always_comb begin
        mrg = '0;
        for (int b = 0; b < 32; b++) mrg[b*8+:8] = be[0][b] ? wflat[b*8+:8] : mem0[addr[0]][b*8+:8];
    end

    always @(posedge clk) begin
        if (pl_en) begin
            if (pl_m) mem1[pl_l] <= pl_d;
            else mem0[pl_l] <= pl_d;
        end
        if (rd[0]) rdata[0] <= mem0[addr[0]];
        if (rd[1]) rdata[1] <= mem1[addr[1]];
        if (wr[0]) begin
            mem0[addr[0]] <= mrg;
            wcount <= wcount + 1;
            last_be <= be[0];
            last_w4 <= wdata[0][4];
        end
        if (wr[1]) w1count <= w1count + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int l, input int w);
        return mem0[l][w*32+:32];
    endfunction

    task automatic put(input logic m, input int l, input logic [31:0] a, b, c, d);
        pl_en = 1'b1;
        pl_m = m;
        pl_l = 4'(l);
        pl_d = {{4{32'hA5A5A5A5}}, d, c, b, a};
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic put_b(input int base);
        for (int i = 0; i < 4; i++) put(1'b1, base + i, 32'(4*i+1), 32'(4*i+2), 32'(4*i+3), 32'(4*i+4));
    endtask

    task automatic clear_c(input int base);
        for (int i = 0; i < 4; i++) put(1'b0, (base + i) % 16, 0, 0, 0, 0);
    endtask

    task automatic start(input int ab, bb, cb);
        host_regs[1] = 32'(ab) | (32'(bb) << 8) | (32'(cb) << 16);
        host_regs[0] = 32'd1;
        pulse[0] = 1'b1;
        @(posedge clk);
        #1 pulse[0] = 1'b0;
        host_regs[0] = 32'd0;
    endtask

    task automatic run(input int ab, bb, cb, restart);
        int c, ws;
        ws = wcount;
        start(ab, bb, cb);
        c = 1;
        check("busy_c1", 64'(busy), 64'd1);
        check("done_clr", 64'(done), 64'd0);
        check("sat_clr", 64'(sat), 64'd0);
        check("rd_c1", 64'(rd), 64'd3);
        check("addr_a_c1", 64'(addr[0]), 64'(ab % 16));
        while (done == 1'b0 && c < 200) begin
            if (c == restart) begin
                host_regs[0] = 32'd1;
                pulse[0] = 1'b1;
            end
            @(posedge clk);
            #1 pulse[0] = 1'b0;
            host_regs[0] = 32'd0;
            c++;
        end
        check("done_cycle", 64'(c), 64'd26);
        check("write_count", 64'(wcount - ws), 64'd4);
        check("busy_in_done", 64'(busy), 64'd0);
    endtask

    task automatic check_c_eq_b(input int cb);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) check("c_eq_b", 64'(word((cb + i) % 16, j)), 64'(4*i+j+1));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_status1", 64'(data_out[1]), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd1);
        check("rst_rdwr", 64'({rd, wr}), 64'd0);
        check("rst_be", 64'(be), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        put(1'b0, 0, 1, 2, 0, 0);
        put(1'b0, 1, 3, 4, 0, 0);
        put(1'b0, 2, 0, 0, 0, 0);
        put(1'b0, 3, 0, 0, 0, 0);
        put(1'b1, 0, 5, 6, 0, 0);
        put(1'b1, 1, 7, 8, 0, 0);
        put(1'b1, 2, 0, 0, 0, 0);
        put(1'b1, 3, 0, 0, 0, 0);
        run(0, 0, 8, 0);
        check("c00", 64'(word(8, 0)), 64'd19);
        check("c01", 64'(word(8, 1)), 64'd22);
        check("c02", 64'(word(8, 2)), 64'd0);
        check("c10", 64'(word(9, 0)), 64'd43);
        check("c11", 64'(word(9, 1)), 64'd50);
        check("c20", 64'(word(10, 0)), 64'd0);
        check("be_mask", 64'(last_be), 64'h0000FFFF);
        check("wdata_unused", 64'(last_w4), 64'd0);
        check("valid_done", 64'(valid_out), 64'd3);
        check("status2", 64'(data_out[2]), 64'd0);
        check("sat_small", 64'(sat), 64'd0);

        for (int i = 0; i < 4; i++) put(1'b0, 4 + i, 32'(i == 0), 32'(i == 1), 32'(i == 2), 32'(i == 3));
        put_b(4);
        run(4, 4, 12, 0);
        check_c_eq_b(12);

        put(1'b0, 14, 0, 1, 0, 0);
        put(1'b0, 15, 1, 0, 0, 0);
        put(1'b0, 0, 0, 0, 0, 1);
        put(1'b0, 1, 0, 0, 1, 0);
        put_b(8);
        run(14, 8, 13, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) check("wrap", 64'(word((13 + i) % 16, j)), 64'(4*p[i]+j+1));

        clear_c(12);
        run(4, 4, 12, 10);
        check_c_eq_b(12);
        w0 = wcount;
        repeat (20) @(posedge clk);
        #1;
        check("no_rerun_wr", 64'(wcount - w0), 64'd0);
        check("no_rerun_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 4; i++) begin
            put(1'b0, i, '1, '1, '1, '1);
            put(1'b1, i, '1, '1, '1, '1);
        end
        run(0, 0, 8, 0);
        check("ff_c00", 64'(word(8, 0)), 64'(FF_C));
        check("ff_c33", 64'(word(11, 3)), 64'(FF_C));
        check("ff_sat", 64'(sat), 64'(FF_SAT));

        clear_c(8);
        w0 = wcount;
        start(4, 4, 8);
        n = 0;
        while (wcount - w0 < 1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("abort_reach", 64'(wcount - w0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_wr", 64'(wr), 64'd0);
        check("abort_addr", 64'(addr), 64'd0);
        check("abort_be", 64'(be), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_wcount", 64'(wcount - w0), 64'd1);
        check("abort_row1", 64'(word(9, 0)), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(4, 4, 8, 0);
        check_c_eq_b(8);
        check("mem1_writes", 64'(w1count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
